trap_unit: RTL and testbench
============================

Name: trap_unit

Overview:
- Machine-mode trap sequencer. Sits directly upstream of the CSR file and drives its implicit read/write ports.
- Takes synchronous exceptions, external interrupts and MRET from the pipeline.
- Reads mstatus/mtvec/mepc, then writes the trap state (mstatus, mepc, mcause, mtval).
- Produces a one-cycle PC redirect and the new privilege mode for fetch.

Parameters:
VECTORED_EN, 1, enable mtvec vectored mode (MODE field = 1) for interrupts
RESET_MODE, 2'b11, privilege reported on new_mode after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
exc_valid  in  1  synchronous exception request
exc_cause  in  5  exception code
exc_tval  in  32  faulting value for mtval
trap_pc  in  32  PC of the trapping/interrupted instruction
irq_valid  in  1  pending enabled interrupt (level)
irq_cause  in  5  interrupt code
mret_valid  in  1  MRET retiring
mode  in  2  current privilege
csr_impl_read_enable  out  4  implicit read enables, slot i
csr_impl_addrs_r  out  48  implicit read addresses, 12 bits per slot
csr_impl_csr  in  128  implicit read data, combinational, 32 bits per slot
csr_impl_write_enable  out  4  implicit write enables
csr_impl_addrs_w  out  48  implicit write addresses
csr_impl_write_data  out  128  implicit write data
busy  out  1  sequencer active; pipeline must stall/flush
redirect_valid  out  1  one-cycle redirect pulse
redirect_pc  out  32  target PC
new_mode  out  2  privilege after redirect

Behaviour:
- Reset:
  - state = IDLE; busy, redirect_valid, write enables = 0.
  - redirect_pc = 0; new_mode = RESET_MODE; captured registers cleared.
  - Reset mid-sequence aborts the sequence with no CSR write.
- Read slots in IDLE (constantly enabled): slot0 = 0x300 mstatus, slot1 = 0x305 mtvec, slot2 = 0x341 mepc, slot3 = 0; read enables = 4'b0111. In other states, read enables = 0.
- Acceptance in IDLE, cycle N. Priority: exc > MRET > irq.
  - irq is accepted only if mstatus[3]=1 or mode != 2'b11.
  - MRET with mode != 2'b11 is converted to an exception with cause 2 and tval 0.
  - At the edge of N, the unit captures type, cause, tval, trap_pc, mode and the three CSR reads, then enters WRITE.
- Inputs ignored while busy; no queuing. Requests must be held or re-presented by the pipeline.
- WRITE (N+1), busy = 1, single cycle.
  - Trap, slot0 mstatus: MPP[12:11] = captured mode, MPIE[7] = old MIE[3], MIE = 0; other bits unchanged.
  - Trap, slot1 mepc: {trap_pc[31:2], 2'b00}.
  - Trap, slot2 mcause: {is_irq, 26'b0, cause}.
  - Trap, slot3 mtval: exc_tval for exceptions, 0 for irq.
  - Trap: write enables = 4'b1111.
  - MRET: slot0 only (enables = 4'b0001). MIE = MPIE, MPIE = 1, MPP = 2'b00.
  - An explicit CSR write to the same address in the same cycle wins inside the CSR file. No retry.
- REDIRECT (N+2), busy = 1, redirect_valid = 1 for exactly one cycle; then IDLE at N+3.
  - Trap base = {mtvec[31:2], 2'b00}.
  - If VECTORED_EN, mtvec[1:0] = 1 and the trap is an irq: redirect_pc = base + 4*cause.
  - Otherwise redirect_pc = base.
  - Trap: new_mode = 2'b11. MRET: redirect_pc = captured mepc, new_mode = captured MPP.
- redirect_pc and new_mode hold their last values outside REDIRECT.
- mtvec[1:0] = 2 or 3 is treated as direct mode.
- Vector addition wraps modulo 2^32.
- A new request in the cycle that REDIRECT returns to IDLE is sampled normally at N+3 (back-to-back traps allowed).

Test Plan:
- Exception: mtvec=0x100, mstatus=0x8, mode=3, exc cause 2, trap_pc=0x203, tval=0xDEAD -> N+1 writes mstatus=0x1880, mepc=0x200, mcause=0x2, mtval=0xDEAD; N+2 redirect 0x100, mode 3.
- Vectored irq: mtvec=0x101, mstatus=0x8, irq cause 7 -> mcause=0x80000007, mtval=0, redirect 0x11C. Repeat with mstatus=0 in M-mode -> not accepted, busy stays 0.
- MRET: mstatus=0x80, mepc=0x400, mode=3 -> only slot0 written with 0x88; redirect 0x400, new_mode 0. MRET in mode 0 -> cause 2 exception path.
- Simultaneous exc, mret and irq in one cycle -> exception taken; a second exc_valid during busy is ignored; back-to-back exception at N+3 is accepted.
- Reset asserted during WRITE -> no write enable next cycle, busy=0, redirect_valid never pulses, new_mode=RESET_MODE.

Source files
------------

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap sequencer feeding the CSR file's implicit ports.
//
// Accepts synchronous exceptions, external interrupts and MRET from the
// pipeline. The request and the three CSR reads (mstatus, mtvec, mepc) are
// captured in IDLE. The trap state is written in WRITE. A one-cycle redirect
// to fetch follows in REDIRECT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | reads enabled, sampling exc/mret/irq requests
// WRITE    | busy, implicit CSR writes (4 slots for trap, slot0 for MRET)
// REDIRECT | busy, redirect_valid pulse with redirect_pc/new_mode
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   exc_valid/cause/tval    synchronous exception request
//   trap_pc                 PC of the trapping/interrupted instruction
//   irq_valid/cause         pending enabled interrupt (level)
//   mret_valid              MRET retiring
//   mode                    current privilege
//   csr_impl_*              implicit CSR read/write ports, 4 slots
//   busy                    sequencer active
//   redirect_valid/pc       one-cycle fetch redirect
//   new_mode                privilege after redirect
module trap_unit #(
    parameter bit         VECTORED_EN = 1'b1,
    parameter logic [1:0] RESET_MODE  = 2'b11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exc_valid,
    input  logic [4:0]   exc_cause,
    input  logic [31:0]  exc_tval,
    input  logic [31:0]  trap_pc,
    input  logic         irq_valid,
    input  logic [4:0]   irq_cause,
    input  logic         mret_valid,
    input  logic [1:0]   mode,
    output logic [3:0]   csr_impl_read_enable,
    output logic [47:0]  csr_impl_addrs_r,
    input  logic [127:0] csr_impl_csr,
    output logic [3:0]   csr_impl_write_enable,
    output logic [47:0]  csr_impl_addrs_w,
    output logic [127:0] csr_impl_write_data,
    output logic         busy,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic [1:0]   new_mode
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        is_irq_q, is_mret_q;
    logic [4:0]  cause_q;
    logic [31:0] tval_q;
    logic [29:0] pc_q;
    logic [1:0]  mode_q;
    logic [31:0] mstatus_q, mtvec_q, mepc_q;
    logic [31:0] redirect_pc_q;
    logic [1:0]  new_mode_q;

    logic [31:0] rd_mstatus, rd_mtvec, rd_mepc;
    logic        accept, take_irq, take_mret;
    logic [4:0]  cause_sel;
    logic [31:0] tval_sel;

    logic [31:0] mstatus_new;
    logic [31:0] trap_base;
    logic [31:0] redirect_pc_d;
    logic [1:0]  new_mode_d;

    // Slot 3 read data is never requested (address 0, enable 0).
    logic unused_rd_slot3;
    assign unused_rd_slot3 = ^csr_impl_csr[127:96];

    assign rd_mstatus = csr_impl_csr[31:0];
    assign rd_mtvec   = csr_impl_csr[63:32];
    assign rd_mepc    = csr_impl_csr[95:64];

    // Request arbitration: exc > MRET > irq. MRET outside M-mode becomes
    // an illegal-instruction exception (cause 2, tval 0).
    always_comb begin
        accept    = 1'b0;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        cause_sel = 5'd0;
        tval_sel  = 32'd0;
        if (exc_valid) begin
            accept    = 1'b1;
            cause_sel = exc_cause;
            tval_sel  = exc_tval;
        end else if (mret_valid) begin
            accept = 1'b1;
            if (mode == 2'b11) begin
                take_mret = 1'b1;
            end else begin
                cause_sel = 5'd2;
            end
        end else if (irq_valid && (rd_mstatus[3] || mode != 2'b11)) begin
            accept    = 1'b1;
            take_irq  = 1'b1;
            cause_sel = irq_cause;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_WRITE;
            S_WRITE:    state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // mstatus update: trap pushes MIE into MPIE and records the old mode;
    // MRET pops MPIE back into MIE and drops MPP to U.
    always_comb begin
        mstatus_new = mstatus_q;
        if (is_mret_q) begin
            mstatus_new[3]     = mstatus_q[7];
            mstatus_new[7]     = 1'b1;
            mstatus_new[12:11] = 2'b00;
        end else begin
            mstatus_new[12:11] = mode_q;
            mstatus_new[7]     = mstatus_q[3];
            mstatus_new[3]     = 1'b0;
        end
    end

    // mtvec MODE values 2 and 3 fall back to direct.
    always_comb begin
        trap_base = {mtvec_q[31:2], 2'b00};
        if (is_mret_q) begin
            redirect_pc_d = mepc_q;
            new_mode_d    = mstatus_q[12:11];
        end else begin
            redirect_pc_d = trap_base;
            if (VECTORED_EN && mtvec_q[1:0] == 2'b01 && is_irq_q) begin
                redirect_pc_d = trap_base + {25'd0, cause_q, 2'b00};
            end
            new_mode_d = 2'b11;
        end
    end

    always_comb begin
        csr_impl_read_enable  = 4'b0000;
        csr_impl_addrs_r      = {12'h000, CSR_MEPC, CSR_MTVEC, CSR_MSTATUS};
        csr_impl_write_enable = 4'b0000;
        csr_impl_addrs_w      = 48'd0;
        csr_impl_write_data   = 128'd0;
        if (state_q == S_IDLE) begin
            csr_impl_read_enable = 4'b0111;
        end
        if (state_q == S_WRITE) begin
            csr_impl_addrs_w[11:0]     = CSR_MSTATUS;
            csr_impl_write_data[31:0]  = mstatus_new;
            if (is_mret_q) begin
                csr_impl_write_enable = 4'b0001;
            end else begin
                csr_impl_write_enable        = 4'b1111;
                csr_impl_addrs_w[23:12]      = CSR_MEPC;
                csr_impl_addrs_w[35:24]      = CSR_MCAUSE;
                csr_impl_addrs_w[47:36]      = CSR_MTVAL;
                csr_impl_write_data[63:32]   = {pc_q, 2'b00};
                csr_impl_write_data[95:64]   = {is_irq_q, 26'd0, cause_q};
                csr_impl_write_data[127:96]  = tval_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_irq_q      <= 1'b0;
            is_mret_q     <= 1'b0;
            cause_q       <= 5'd0;
            tval_q        <= 32'd0;
            pc_q          <= 30'd0;
            mode_q        <= 2'b00;
            mstatus_q     <= 32'd0;
            mtvec_q       <= 32'd0;
            mepc_q        <= 32'd0;
            redirect_pc_q <= 32'd0;
            new_mode_q    <= RESET_MODE;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && accept) begin
                is_irq_q  <= take_irq;
                is_mret_q <= take_mret;
                cause_q   <= cause_sel;
                tval_q    <= tval_sel;
                pc_q      <= trap_pc[31:2];
                mode_q    <= mode;
                mstatus_q <= rd_mstatus;
                mtvec_q   <= rd_mtvec;
                mepc_q    <= rd_mepc;
            end
            // Loaded on entry to REDIRECT so the target is stable for the
            // pulse and held afterwards.
            if (state_q == S_WRITE) begin
                redirect_pc_q <= redirect_pc_d;
                new_mode_q    <= new_mode_d;
            end
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign new_mode       = new_mode_q;

endmodule

// File: tb/tb_trap_unit.sv
module tb_trap_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         exc_valid;
    logic [4:0]   exc_cause;
    logic [31:0]  exc_tval;
    logic [31:0]  trap_pc;
    logic         irq_valid;
    logic [4:0]   irq_cause;
    logic         mret_valid;
    logic [1:0]   mode;
    logic [3:0]   csr_impl_read_enable;
    logic [47:0]  csr_impl_addrs_r;
    logic [127:0] csr_impl_csr;
    logic [3:0]   csr_impl_write_enable;
    logic [47:0]  csr_impl_addrs_w;
    logic [127:0] csr_impl_write_data;
    logic         busy;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [1:0]   new_mode;

    int total = 0;
    int bad   = 0;

    trap_unit #(.VECTORED_EN(1'b1), .RESET_MODE(2'b11)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .exc_valid             (exc_valid),
        .exc_cause             (exc_cause),
        .exc_tval              (exc_tval),
        .trap_pc               (trap_pc),
        .irq_valid             (irq_valid),
        .irq_cause             (irq_cause),
        .mret_valid            (mret_valid),
        .mode                  (mode),
        .csr_impl_read_enable  (csr_impl_read_enable),
        .csr_impl_addrs_r      (csr_impl_addrs_r),
        .csr_impl_csr          (csr_impl_csr),
        .csr_impl_write_enable (csr_impl_write_enable),
        .csr_impl_addrs_w      (csr_impl_addrs_w),
        .csr_impl_write_data   (csr_impl_write_data),
        .busy                  (busy),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .new_mode              (new_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [31:0] pc;
        logic        irq;
        logic [4:0]  icause;
        logic        mret;
        logic [1:0]  md;
        logic [31:0] mst;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        acc;
        logic [3:0]  we;
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] rpc;
        logic [1:0]  nm;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        irq_valid  = 1'b0;
    endtask

    task automatic set_csrs(input logic [31:0] mst, input logic [31:0] mtv, input logic [31:0] mep);
        csr_impl_csr = {32'hFFFF_FFFF, mep, mtv, mst};
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exc_valid  = v.exc;
        exc_cause  = v.ecause;
        exc_tval   = v.tval;
        trap_pc    = v.pc;
        irq_valid  = v.irq;
        irq_cause  = v.icause;
        mret_valid = v.mret;
        mode       = v.md;
        set_csrs(v.mst, v.mtvec, v.mepc);
        chk($sformatf("v%0d_rd_en", idx), {44'd0, csr_impl_read_enable}, 48'h7);
        tick;
        idle_inputs;
        set_csrs(32'h0, 32'h0, 32'h0);
        if (v.acc) begin
            chk($sformatf("v%0d_busy_w", idx), {47'd0, busy}, 48'd1);
            chk($sformatf("v%0d_rd_en_w", idx), {44'd0, csr_impl_read_enable}, 48'd0);
            chk($sformatf("v%0d_we", idx), {44'd0, csr_impl_write_enable}, {44'd0, v.we});
            chk($sformatf("v%0d_a0", idx), {36'd0, csr_impl_addrs_w[11:0]}, 48'h300);
            chk($sformatf("v%0d_mstatus", idx), {16'd0, csr_impl_write_data[31:0]}, {16'd0, v.w0});
            if (v.we == 4'b1111) begin
                chk($sformatf("v%0d_a123", idx), {12'd0, csr_impl_addrs_w[47:12]}, 48'h343_342_341);
                chk($sformatf("v%0d_mepc", idx), {16'd0, csr_impl_write_data[63:32]}, {16'd0, v.w1});
                chk($sformatf("v%0d_mcause", idx), {16'd0, csr_impl_write_data[95:64]}, {16'd0, v.w2});
                chk($sformatf("v%0d_mtval", idx), {16'd0, csr_impl_write_data[127:96]}, {16'd0, v.w3});
            end
            tick;
            chk($sformatf("v%0d_rv", idx), {47'd0, redirect_valid}, 48'd1);
            chk($sformatf("v%0d_busy_r", idx), {47'd0, busy}, 48'd1);
            chk($sformatf("v%0d_we_r", idx), {44'd0, csr_impl_write_enable}, 48'd0);
            chk($sformatf("v%0d_rpc", idx), {16'd0, redirect_pc}, {16'd0, v.rpc});
            chk($sformatf("v%0d_nm", idx), {46'd0, new_mode}, {46'd0, v.nm});
            tick;
            chk($sformatf("v%0d_rv_end", idx), {47'd0, redirect_valid}, 48'd0);
            chk($sformatf("v%0d_busy_end", idx), {47'd0, busy}, 48'd0);
            chk($sformatf("v%0d_rpc_hold", idx), {16'd0, redirect_pc}, {16'd0, v.rpc});
            chk($sformatf("v%0d_nm_hold", idx), {46'd0, new_mode}, {46'd0, v.nm});
        end else begin
            chk($sformatf("v%0d_busy_n", idx), {47'd0, busy}, 48'd0);
            chk($sformatf("v%0d_we_n", idx), {44'd0, csr_impl_write_enable}, 48'd0);
            tick;
            chk($sformatf("v%0d_busy_n2", idx), {47'd0, busy}, 48'd0);
            chk($sformatf("v%0d_rv_n", idx), {47'd0, redirect_valid}, 48'd0);
        end
    endtask

    initial begin
        //          exc  ec     tval          pc            irq  ic     mret md     mst           mtvec         mepc          acc  we       w0            w1            w2            w3            rpc           nm
        vecs[0] = '{1'b1, 5'd2, 32'h0000DEAD, 32'h00000203, 1'b0, 5'd0, 1'b0, 2'b11, 32'h00000008, 32'h00000100, 32'h0, 1'b1, 4'b1111, 32'h00001880, 32'h00000200, 32'h00000002, 32'h0000DEAD, 32'h00000100, 2'b11};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 32'h00001000, 1'b1, 5'd7, 1'b0, 2'b11, 32'h00000008, 32'h00000101, 32'h0, 1'b1, 4'b1111, 32'h00001880, 32'h00001000, 32'h80000007, 32'h00000000, 32'h0000011C, 2'b11};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 32'h00001000, 1'b1, 5'd7, 1'b0, 2'b11, 32'h00000000, 32'h00000101, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 32'h00000305, 1'b0, 5'd0, 1'b1, 2'b00, 32'h00000008, 32'h00000200, 32'h00000999, 1'b1, 4'b1111, 32'h00000080, 32'h00000304, 32'h00000002, 32'h00000000, 32'h00000200, 2'b11};
        vecs[4] = '{1'b1, 5'd5, 32'h00000011, 32'h00000040, 1'b1, 5'd3, 1'b1, 2'b11, 32'h00000008, 32'h00000101, 32'h00000777, 1'b1, 4'b1111, 32'h00001880, 32'h00000040, 32'h00000005, 32'h00000011, 32'h00000100, 2'b11};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 32'h00000050, 1'b1, 5'd11, 1'b0, 2'b00, 32'h00000000, 32'h00000103, 32'h0, 1'b1, 4'b1111, 32'h00000000, 32'h00000050, 32'h8000000B, 32'h00000000, 32'h00000100, 2'b11};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 32'h00000060, 1'b1, 5'd31, 1'b0, 2'b11, 32'h00000008, 32'hFFFFFFF1, 32'h0, 1'b1, 4'b1111, 32'h00001880, 32'h00000060, 32'h8000001F, 32'h00000000, 32'h0000006C, 2'b11};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 32'h00000070, 1'b0, 5'd0, 1'b1, 2'b11, 32'h00001808, 32'h00000100, 32'h00000804, 1'b1, 4'b0001, 32'h00000080, 32'h0, 32'h0, 32'h0, 32'h00000804, 2'b11};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 32'h00000080, 1'b0, 5'd0, 1'b1, 2'b11, 32'h00000080, 32'h00000100, 32'h00000400, 1'b1, 4'b0001, 32'h00000088, 32'h0, 32'h0, 32'h0, 32'h00000400, 2'b00};

        reset = 1'b1;
        idle_inputs;
        exc_cause = 5'd0;
        exc_tval  = 32'd0;
        trap_pc   = 32'd0;
        irq_cause = 5'd0;
        mode      = 2'b11;
        set_csrs(32'h0, 32'h0, 32'h0);
        repeat (3) tick;
        reset = 1'b0;

        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_rv", {47'd0, redirect_valid}, 48'd0);
        chk("rst_we", {44'd0, csr_impl_write_enable}, 48'd0);
        chk("rst_rpc", {16'd0, redirect_pc}, 48'd0);
        chk("rst_nm", {46'd0, new_mode}, 48'd3);
        chk("rst_rd_en", {44'd0, csr_impl_read_enable}, 48'h7);
        chk("rst_addrs_r", csr_impl_addrs_r, 48'h000_341_305_300);

        // Request held through busy with a changed cause: ignored while busy,
        // then re-accepted back-to-back once IDLE returns.
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_tval  = 32'h1;
        trap_pc   = 32'h10;
        mode      = 2'b11;
        set_csrs(32'h8, 32'h100, 32'h0);
        tick;
        chk("b2b_busy1", {47'd0, busy}, 48'd1);
        chk("b2b_cause1", {16'd0, csr_impl_write_data[95:64]}, 48'h2);
        exc_cause = 5'd9;
        exc_tval  = 32'h2;
        tick;
        chk("b2b_rv1", {47'd0, redirect_valid}, 48'd1);
        chk("b2b_rpc1", {16'd0, redirect_pc}, 48'h100);
        tick;
        chk("b2b_idle", {47'd0, busy}, 48'd0);
        tick;
        chk("b2b_busy2", {47'd0, busy}, 48'd1);
        chk("b2b_cause2", {16'd0, csr_impl_write_data[95:64]}, 48'h9);
        chk("b2b_tval2", {16'd0, csr_impl_write_data[127:96]}, 48'h2);
        idle_inputs;
        tick;
        tick;
        chk("b2b_done", {47'd0, busy}, 48'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during WRITE aborts; the previous MRET left new_mode = 0.
        exc_valid = 1'b1;
        exc_cause = 5'd4;
        exc_tval  = 32'h55;
        trap_pc   = 32'h90;
        mode      = 2'b11;
        set_csrs(32'h8, 32'h100, 32'h0);
        tick;
        chk("rstw_busy", {47'd0, busy}, 48'd1);
        idle_inputs;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstw_we", {44'd0, csr_impl_write_enable}, 48'd0);
        chk("rstw_busy0", {47'd0, busy}, 48'd0);
        chk("rstw_nm", {46'd0, new_mode}, 48'd3);
        chk("rstw_rpc", {16'd0, redirect_pc}, 48'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstw_rv%0d", k), {47'd0, redirect_valid}, 48'd0);
            chk($sformatf("rstw_bz%0d", k), {47'd0, busy}, 48'd0);
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
